// File: rtl/acumulador_if.sv
// Sample/result bundle between the upstream adder and acumulador.
// The adder side drives the master modport; the accumulator takes the slave modport.
interface acumulador_if #(
    parameter int NUM_BITS = 8
);
    logic [NUM_BITS-1:0] S;
    logic                Z;
    logic                N;
    logic                P;
    logic                valid_in;
    logic                ready_out;
    logic                clear;
    logic [NUM_BITS-1:0] acc;
    logic                acc_z;
    logic                acc_n;
    logic                acc_p;
    logic                ovf;
    logic [3:0]          cnt_z;
    logic [3:0]          cnt_n;
    logic [3:0]          cnt_p;
    logic                valid_out;

    modport master (
        output S, Z, N, P, valid_in, clear,
        input  ready_out, acc, acc_z, acc_n, acc_p,
        input  ovf, cnt_z, cnt_n, cnt_p, valid_out
    );

    modport slave (
        input  S, Z, N, P, valid_in, clear,
        output ready_out, acc, acc_z, acc_n, acc_p,
        output ovf, cnt_z, cnt_n, cnt_p, valid_out
    );
endinterface

// File: rtl/acumulador.sv
// Signed running accumulator with result flags, sticky overflow and flag counters.
// Define SATURATE_EN to clamp on overflow instead of wrapping and stopping in HOLD.
module acumulador #(
    parameter int NUM_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    acumulador_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [NUM_BITS-1:0] MAXV = {1'b0, {(NUM_BITS-1){1'b1}}};
    localparam logic [NUM_BITS-1:0] MINV = {1'b1, {(NUM_BITS-1){1'b0}}};

    state_t              state_q, state_nxt;
    logic [NUM_BITS-1:0] acc_q, acc_nxt;
    logic                ovf_q, ovf_nxt;
    logic                accz_q, accn_q, accp_q;
    logic [3:0]          cz_q, cn_q, cp_q;
    logic                vout_q;
    logic                ready;
    logic                accept;
    logic [NUM_BITS-1:0] sum;
    logic                ovf_det;

    assign ready   = ~bus.clear & (state_q != HOLD);
    assign accept  = bus.valid_in & ready;
    assign sum     = acc_q + bus.S;
    // Same-sign operands whose result flips sign overflowed.
    assign ovf_det = (acc_q[NUM_BITS-1] == bus.S[NUM_BITS-1]) &&
                     (sum[NUM_BITS-1] != acc_q[NUM_BITS-1]);

    // Next state and next accumulator value for an accepted sample.
    always_comb begin
        state_nxt = state_q;
        acc_nxt   = acc_q;
        ovf_nxt   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = bus.S;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = sum;
                    if (ovf_det) begin
                        ovf_nxt = 1'b1;
`ifdef SATURATE_EN
                        acc_nxt = bus.S[NUM_BITS-1] ? MINV : MAXV;
`else
                        state_nxt = HOLD;
`endif
                    end
                end
            end
            HOLD: begin
                state_nxt = HOLD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, accumulator, flags and counters; reset beats clear beats samples.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            accz_q  <= 1'b1;
            accn_q  <= 1'b0;
            accp_q  <= 1'b1;
            ovf_q   <= 1'b0;
            cz_q    <= 4'd0;
            cn_q    <= 4'd0;
            cp_q    <= 4'd0;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            acc_q   <= acc_nxt;
            accz_q  <= (acc_nxt == '0);
            accn_q  <= acc_nxt[NUM_BITS-1];
            accp_q  <= ~acc_nxt[0];
            ovf_q   <= ovf_nxt;
            vout_q  <= accept;
            if (accept && bus.Z && cz_q != 4'd15) cz_q <= cz_q + 4'd1;
            if (accept && bus.N && cn_q != 4'd15) cn_q <= cn_q + 4'd1;
            if (accept && bus.P && cp_q != 4'd15) cp_q <= cp_q + 4'd1;
        end
    end

    assign bus.ready_out = ready;
    assign bus.acc       = acc_q;
    assign bus.acc_z     = accz_q;
    assign bus.acc_n     = accn_q;
    assign bus.acc_p     = accp_q;
    assign bus.ovf       = ovf_q;
    assign bus.cnt_z     = cz_q;
    assign bus.cnt_n     = cn_q;
    assign bus.cnt_p     = cp_q;
    assign bus.valid_out = vout_q;
endmodule

// File: tb/tb_acumulador.sv
// Directed bench for acumulador at NUM_BITS=8.
// Expected values are hand-computed; SATURATE_EN selects the clamping expectations.
module tb_acumulador;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    acumulador_if #(.NUM_BITS(8)) bus ();

    acumulador #(.NUM_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [7:0] s, input logic z, input logic n,
                       input logic p, input logic v, input logic c);
        bus.S        = s;
        bus.Z        = z;
        bus.N        = n;
        bus.P        = p;
        bus.valid_in = v;
        bus.clear    = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drv(8'd0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_acc", bus.acc, 8'h00);
        chk("rst_z", bus.acc_z, 1);
        chk("rst_n", bus.acc_n, 0);
        chk("rst_p", bus.acc_p, 1);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_cnt", {bus.cnt_z, bus.cnt_n, bus.cnt_p}, 12'h000);
        chk("rst_vout", bus.valid_out, 0);
        chk("rst_ready", bus.ready_out, 1);

        // 5, 3, -2 -> 5, 8, 6
        drv(8'd5, 0, 0, 0, 1, 0);
        tick();
        chk("s1_acc", bus.acc, 8'h05);
        chk("s1_vout", bus.valid_out, 1);
        chk("s1_p", bus.acc_p, 0);
        drv(8'd3, 0, 0, 0, 1, 0);
        tick();
        chk("s2_acc", bus.acc, 8'h08);
        chk("s2_vout", bus.valid_out, 1);
        chk("s2_p", bus.acc_p, 1);
        drv(8'hFE, 0, 1, 1, 1, 0);
        tick();
        chk("s3_acc", bus.acc, 8'h06);
        chk("s3_vout", bus.valid_out, 1);
        drv(8'd0, 0, 0, 0, 0, 0);
        tick();
        chk("s4_vout", bus.valid_out, 0);
        chk("s4_cntp", bus.cnt_p, 1);
        chk("s4_cntn", bus.cnt_n, 1);
        chk("s4_cntz", bus.cnt_z, 0);
        chk("s4_ovf", bus.ovf, 0);

        // overflow: 100 + 50
        drv(8'd0, 0, 0, 0, 0, 1);
        tick();
        drv(8'd100, 0, 0, 1, 1, 0);
        tick();
        chk("o1_acc", bus.acc, 8'd100);
        drv(8'd50, 0, 0, 1, 1, 0);
        tick();
`ifdef SATURATE_EN
        chk("o2_acc", bus.acc, 8'h7F);
        chk("o2_ovf", bus.ovf, 1);
        chk("o2_ready", bus.ready_out, 1);
        chk("o2_n", bus.acc_n, 0);
`else
        chk("o2_acc", bus.acc, 8'h96);
        chk("o2_ovf", bus.ovf, 1);
        chk("o2_ready", bus.ready_out, 0);
        chk("o2_n", bus.acc_n, 1);
        chk("o2_p", bus.acc_p, 1);

        // HOLD ignores samples
        drv(8'd1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_acc", bus.acc, 8'h96);
            chk("h_vout", bus.valid_out, 0);
            chk("h_ready", bus.ready_out, 0);
        end
`endif
        drv(8'd0, 0, 0, 0, 0, 1);
        tick();
        chk("c_acc", bus.acc, 8'h00);
        chk("c_z", bus.acc_z, 1);
        chk("c_ovf", bus.ovf, 0);
        chk("c_ready_clr", bus.ready_out, 0);
        drv(8'd0, 0, 0, 0, 0, 0);
        #1;
        chk("c_ready", bus.ready_out, 1);
        // IDLE loads, does not add
        drv(8'd4, 0, 0, 1, 1, 0);
        tick();
        chk("c_load", bus.acc, 8'h04);
        chk("c_cntp", bus.cnt_p, 1);

        // clear wins over a sample in ACCUM
        drv(8'd7, 1, 0, 0, 1, 1);
        tick();
        chk("cv_acc", bus.acc, 8'h00);
        chk("cv_cnt", {bus.cnt_z, bus.cnt_n, bus.cnt_p}, 12'h000);
        chk("cv_vout", bus.valid_out, 0);

        // counter saturation
        drv(8'd0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cntz", bus.cnt_z, 15);
        chk("sat_cntp", bus.cnt_p, 15);
        chk("sat_cntn", bus.cnt_n, 0);
        chk("sat_acc", bus.acc, 8'h00);
        chk("sat_z", bus.acc_z, 1);
        chk("sat_vout", bus.valid_out, 1);

        // reset beats a sample in ACCUM
        drv(8'd9, 0, 0, 0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_acc", bus.acc, 8'h00);
        chk("r_flags", {bus.acc_z, bus.acc_n, bus.acc_p}, 3'b101);
        chk("r_ovf", bus.ovf, 0);
        chk("r_cnt", {bus.cnt_z, bus.cnt_n, bus.cnt_p}, 12'h000);
        chk("r_vout", bus.valid_out, 0);
        chk("r_ready", bus.ready_out, 1);
        tick();
        chk("r_load", bus.acc, 8'h09);
        chk("r_lvout", bus.valid_out, 1);
        drv(8'd1, 0, 0, 0, 1, 0);
        tick();
        chk("r_add", bus.acc, 8'h0A);
        drv(8'd0, 0, 0, 0, 0, 0);
        tick();
        chk("r_idle", bus.valid_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
